ordenador_seq: RTL and testbench
================================

ORDENADOR_SEQ -- requirements
Module: ordenador_seq

Interface
REQ-001 Parameter N, default 4, number of entries per batch (N >= 2).
REQ-002 Parameter W, default 4, magnitude width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_mag/in_sinal hold an entry to load.
REQ-006 in_ready  output  1  block accepts an entry this cycle.
REQ-007 in_mag  input  W  magnitude of the entry being loaded.
REQ-008 in_sinal  input  1  sign of the entry (1 = negative).
REQ-009 out_valid  output  1  out_mag/out_sinal hold a sorted entry.
REQ-010 out_ready  input  1  consumer takes the sorted entry this cycle.
REQ-011 out_mag  output  W  magnitude of the current sorted entry.
REQ-012 out_sinal  output  1  sign of the current sorted entry.
REQ-013 ocupado  output  1  high in ORDENA and SAIDA.

Function
REQ-014 The FSM SHALL have three states: CARGA, ORDENA and SAIDA.
REQ-015 CARGA: in_ready = 1, out_valid = 0; on in_valid&&in_ready, store {in_sinal, in_mag} at slot load_idx and increment load_idx.
REQ-016 Acceptance of the N-th entry SHALL move the FSM to ORDENA on that same edge.
REQ-017 ORDENA: bubble sort, exactly one compare-and-maybe-swap per cycle, N*(N-1)/2 cycles (6 for N=4), fixed latency, no early exit.
REQ-018 Pass p = 0..N-2, index j = 0..N-2-p; compare slot j (a) with slot j+1 (b); swap on the edge iff maior.
REQ-019 Ordering SHALL be numeric sign-magnitude: negative < zero < positive; among negatives, larger magnitude is smaller; -0 equals +0.
REQ-020 On igual, no swap (stable sort); stored encodings SHALL be output unchanged (an entered -0 leaves as -0).
REQ-021 After the last compare the FSM SHALL enter SAIDA; first out_valid occurs N*(N-1)/2 + 1 cycles after the last input acceptance edge.
REQ-022 SAIDA: out_valid = 1, in_ready = 0, out_* = slot out_idx; out_* SHALL be stable while out_valid&&!out_ready.
REQ-023 On out_valid&&out_ready, out_idx increments; the N-th transfer SHALL return the FSM to CARGA with both indices at 0.
REQ-024 in_valid is ignored outside CARGA; out_ready is ignored outside SAIDA.
REQ-025 ocupado = 1 in ORDENA and SAIDA, 0 in CARGA.

Reset
REQ-026 While rst_n = 0: FSM = CARGA; load_idx, out_idx, pass and compare counters = 0; all slots = 0.
REQ-027 Outputs during reset: in_ready = 0, out_valid = 0, out_mag = 0, out_sinal = 0, ocupado = 0; in_ready rises in the first cycle after deassertion.
REQ-028 Reset asserted mid-load, mid-sort or mid-output SHALL discard the batch immediately, with no partial output afterwards.

Structure
REQ-029 State encoding, N, W and the compare-count constant N*(N-1)/2 SHALL live in a shared package ordenador_pkg.
REQ-030 Exactly one comparador instance SHALL perform all compares (a = slot j, b = slot j+1); no other magnitude comparison logic is permitted.
REQ-031 Slot storage SHALL be a flip-flop register file of N entries of W+1 bits; indices SHALL be sized for N.

Verification
REQ-032 Load +3, -5, 0, +7 -> ocupado high for 6 cycles, then outputs -5, 0, +3, +7; first out_valid 7 cycles after the 4th acceptance.
REQ-033 Load -0, +0, -2, -2 (distinct tags via order) -> outputs -2, -2, -0, +0 in load order within ties; encodings unchanged.
REQ-034 Output phase with out_ready low for 3 cycles on the 2nd entry -> out_valid stays high, out_* stable, no entry skipped or repeated.
REQ-035 Drive in_valid continuously during ORDENA/SAIDA -> in_ready = 0, no entry stored; the next batch starts cleanly after the 4th output transfer.
REQ-036 Assert rst_n low during the 3rd compare cycle -> outputs go to reset values immediately; a new batch +15, -15, +1, -1 sorts to -15, -1, +1, +15.
REQ-037 Load the 4 entries back-to-back, then consume with out_ready held high -> sort cycles = 6, outputs on 4 consecutive cycles, in_ready high on the next cycle.

Source files
------------

// File: rtl/ordenador_pkg.sv
// ordenador_pkg: shared FSM encoding, default sizes and compare count for ordenador_seq
package ordenador_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 4;
  typedef enum logic [1:0] {CARGA, ORDENA, SAIDA} estado_t;
  function automatic int n_cmp(input int n);
    return n * (n - 1) / 2;
  endfunction
  localparam int N_CMP = n_cmp(N_DEF);
endpackage

// File: rtl/ordenador_comparador.sv
// comparador: numeric sign-magnitude compare where -0 equals +0
module comparador #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_mag,
  input  logic         a_sinal,
  input  logic [W-1:0] b_mag,
  input  logic         b_sinal,
  output logic         maior,
  output logic         igual
);
  logic signed [W+1:0] va, vb;
  assign va = a_sinal ? -$signed({2'b00, a_mag}) : $signed({2'b00, a_mag});
  assign vb = b_sinal ? -$signed({2'b00, b_mag}) : $signed({2'b00, b_mag});
  assign maior = va > vb;
  assign igual = va == vb;
endmodule

// File: rtl/ordenador_seq.sv
// ordenador_seq: loads N sign-magnitude entries, bubble-sorts them one compare per cycle,
// then streams them out in ascending numeric order
module ordenador_seq
  import ordenador_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_mag,
  input  logic         in_sinal,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_mag,
  output logic         out_sinal,
  output logic         ocupado
);
  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);
  estado_t estado;
  logic ativo;
  logic [IW-1:0] load_idx, out_idx, pass, idx;
  logic [W:0] slot [N];
  logic [W:0] a, b;
  logic maior, igual, troca;
  assign a = slot[idx];
  assign b = slot[idx + IW'(1)];
  comparador #(.W(W)) u_cmp (
    .a_mag  (a[W-1:0]),
    .a_sinal(a[W]),
    .b_mag  (b[W-1:0]),
    .b_sinal(b[W]),
    .maior  (maior),
    .igual  (igual)
  );
  // equal keys never swap, which keeps the sort stable
  assign troca = maior && !igual;
  // ativo holds in_ready low through reset and rises on the first edge after release
  assign in_ready = ativo && estado == CARGA;
  assign out_valid = estado == SAIDA;
  assign {out_sinal, out_mag} = out_valid ? slot[out_idx] : '0;
  assign ocupado = estado != CARGA;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= CARGA;
      ativo    <= 1'b0;
      load_idx <= '0;
      out_idx  <= '0;
      pass     <= '0;
      idx      <= '0;
      for (int i = 0; i < N; i++) slot[i] <= '0;
    end else begin
      ativo <= 1'b1;
      case (estado)
        CARGA: if (in_valid && in_ready) begin
          slot[load_idx] <= {in_sinal, in_mag};
          load_idx <= (load_idx == LAST) ? '0 : load_idx + 1'b1;
          if (load_idx == LAST) estado <= ORDENA;
        end
        ORDENA: begin
          if (troca) begin
            slot[idx] <= b;
            slot[idx + IW'(1)] <= a;
          end
          if (idx == LAST_PASS - pass) begin
            idx <= '0;
            pass <= (pass == LAST_PASS) ? '0 : pass + 1'b1;
            if (pass == LAST_PASS) estado <= SAIDA;
          end else idx <= idx + 1'b1;
        end
        SAIDA: if (out_ready) begin
          out_idx <= (out_idx == LAST) ? '0 : out_idx + 1'b1;
          if (out_idx == LAST) estado <= CARGA;
        end
        default: estado <= CARGA;
      endcase
    end
  end
endmodule

// File: tb/tb_ordenador_seq.sv
// tb_ordenador_seq: table vectors, hand-written corner sequences and random batches
// checked against a rank-based stable sort model
module tb_ordenador_seq;
  import ordenador_pkg::*;
  typedef logic [3:0][4:0] lote_t;
  typedef struct {
    lote_t ent;
    lote_t exp;
    int    stall;
    bit    hold;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, in_sinal = 0, out_ready = 0;
  logic in_ready, out_valid, out_sinal, ocupado;
  logic [3:0] in_mag = 0, out_mag;
  int n_chk = 0, n_fail = 0;
  vec_t tab[4];
  ordenador_seq #(.N(4), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_sinal(in_sinal), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_sinal(out_sinal), .ocupado(ocupado)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic lote_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    lote_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction
  // each entry lands at its rank: count of smaller values plus equal values loaded earlier
  function automatic lote_t modelo(input lote_t e);
    lote_t r;
    int v[4];
    for (int i = 0; i < 4; i++) v[i] = e[i][4] ? -int'(e[i][3:0]) : int'(e[i][3:0]);
    for (int i = 0; i < 4; i++) begin
      int rk = 0;
      for (int j = 0; j < 4; j++) if (v[j] < v[i] || (v[j] == v[i] && j < i)) rk++;
      r[rk] = e[i];
    end
    return r;
  endfunction
  task automatic carrega(input lote_t e);
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      in_valid = 1; in_sinal = e[i][4]; in_mag = e[i][3:0];
      @(negedge clk);
      while (!in_ready && t < 20) begin t++; @(negedge clk); end
      if (!in_ready) chk("load_ready", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask
  task automatic coleta(input lote_t exp, input int stall_k, input bit hold, input bit rnd);
    int cyc = 1, ocup = 0, k = 0, stalled = 0, ciclos = 0;
    if (hold) begin in_valid = 1; in_sinal = 1; in_mag = 4'hA; end
    while (!out_valid && cyc < 40) begin
      if (hold) chk("in_ready_sort", int'(in_ready), 0);
      if (ocupado) ocup++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("first_valid_cycle", cyc, N_CMP + 1);
    chk("ocupado_sort_cycles", ocup, N_CMP);
    while (k < 4 && ciclos < 100) begin
      logic rdy;
      if (rnd) rdy = 1'($urandom_range(0, 1));
      else if (k == stall_k && stalled < 3) begin rdy = 0; stalled++; end
      else rdy = 1;
      out_ready = rdy;
      @(negedge clk);
      chk("out_valid", int'(out_valid), 1);
      chk("out_entry", int'({out_sinal, out_mag}), int'(exp[k]));
      chk("ocupado_out", int'(ocupado), 1);
      if (hold) chk("in_ready_out", int'(in_ready), 0);
      @(posedge clk); #1;
      if (rdy) k++;
      ciclos++;
    end
    out_ready = 0;
    in_valid = 0;
    chk("transfers", k, 4);
    if (!rnd) chk("out_cycles", ciclos, 4 + (stall_k >= 0 ? 3 : 0));
    chk("in_ready_after", int'(in_ready), 1);
    chk("out_valid_after", int'(out_valid), 0);
  endtask
  initial begin
    tab[0] = '{mk(5'b00011, 5'b10101, 5'b00000, 5'b00111), mk(5'b10101, 5'b00000, 5'b00011, 5'b00111), 1, 0};
    tab[1] = '{mk(5'b10000, 5'b00000, 5'b10010, 5'b10010), mk(5'b10010, 5'b10010, 5'b10000, 5'b00000), -1, 1};
    tab[2] = '{mk(5'b00011, 5'b10101, 5'b00000, 5'b00111), mk(5'b10101, 5'b00000, 5'b00011, 5'b00111), -1, 0};
    tab[3] = '{mk(5'b00000, 5'b10111, 5'b10000, 5'b00111), mk(5'b10111, 5'b00000, 5'b10000, 5'b00111), -1, 0};
    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_mag", int'(out_mag), 0);
    chk("rst_out_sinal", int'(out_sinal), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("in_ready_post_rst", int'(in_ready), 1);
    for (int v = 0; v < 4; v++) begin
      carrega(tab[v].ent);
      coleta(tab[v].exp, tab[v].stall, tab[v].hold, 0);
    end
    carrega(mk(5'b00001, 5'b10011, 5'b00110, 5'b10000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midsort_out_valid", int'(out_valid), 0);
    chk("midsort_in_ready", int'(in_ready), 0);
    chk("midsort_ocupado", int'(ocupado), 0);
    chk("midsort_out", int'({out_sinal, out_mag}), 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("midsort_released_ready", int'(in_ready), 1);
    chk("midsort_no_partial", int'(out_valid), 0);
    carrega(mk(5'b01111, 5'b11111, 5'b00001, 5'b10001));
    coleta(mk(5'b11111, 5'b10001, 5'b00001, 5'b01111), -1, 0, 0);
    for (int r = 0; r < 20; r++) begin
      lote_t e;
      for (int i = 0; i < 4; i++) e[i] = 5'($urandom_range(0, 31));
      carrega(e);
      coleta(modelo(e), -1, r[0], 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
